// File: rtl/dac_sample_feeder.sv
// Sample feeder for the first-order sigma-delta DAC: a small FIFO is popped once per
// audio period, and the output ramps linearly from the previous sample to the new one.
module dac_sample_feeder #(
    parameter int RATE  = 1515,
    parameter int SHIFT = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic signed [15:0]         in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [15:0]         sample_out,
    output logic                       fetch,
    output logic                       underrun,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int PH_W   = $clog2(RATE);
    localparam int ACC_W  = DATA_W + SHIFT;
    localparam int RC_W   = SHIFT + 1;

    function automatic logic signed [ACC_W-1:0] ext_diff(input logic signed [DATA_W:0] d);
        return ACC_W'(d);
    endfunction

    // Arithmetic floor of the scaled accumulator back to sample precision.
    function automatic logic signed [DATA_W-1:0] acc_to_sample(input logic signed [ACC_W-1:0] a);
        return DATA_W'(a >>> SHIFT);
    endfunction

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [LVL_W-1:0]         level_q;
    logic [PH_W-1:0]          phase;

    logic signed [DATA_W:0]   diff_p0;
    logic signed [DATA_W-1:0] target_p0;
    logic [RC_W-1:0]          ramp_cnt_p0;
    logic signed [ACC_W-1:0]  acc_p1;

    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic signed [DATA_W-1:0] head;
    logic signed [DATA_W:0]   diff_new;

    assign fifo_empty = (level_q == '0);
    assign in_ready   = reset_n & enable & (level_q != LVL_W'(DEPTH));
    assign fetch      = reset_n & enable & (phase == '0);
    assign underrun   = fetch & fifo_empty;
    assign push       = in_valid & in_ready;
    assign pop        = fetch & ~fifo_empty;
    assign head       = mem[rd_ptr];
    assign diff_new   = {head[DATA_W-1], head} - {target_p0[DATA_W-1], target_p0};
    assign sample_out = acc_to_sample(acc_p1);
    assign level      = level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level_q     <= '0;
            phase       <= '0;
            diff_p0     <= '0;
            target_p0   <= '0;
            ramp_cnt_p0 <= '0;
            acc_p1      <= '0;
        end else if (!enable) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level_q     <= '0;
            phase       <= '0;
            diff_p0     <= '0;
            target_p0   <= '0;
            ramp_cnt_p0 <= '0;
            acc_p1      <= '0;
        end else begin
            phase <= (phase == PH_W'(RATE - 1)) ? '0 : phase + PH_W'(1);

            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase

            // Fetch stage -> ramp stage: the first ramp step lands on the fetch edge,
            // so the remaining 2^SHIFT-1 steps are counted by ramp_cnt_p0.
            if (pop) begin
                diff_p0     <= diff_new;
                target_p0   <= head;
                acc_p1      <= acc_p1 + ext_diff(diff_new);
                ramp_cnt_p0 <= RC_W'((1 << SHIFT) - 1);
            end else begin
                if (underrun) diff_p0 <= '0;
                if (ramp_cnt_p0 != '0) begin
                    acc_p1      <= acc_p1 + ext_diff(diff_p0);
                    ramp_cnt_p0 <= ramp_cnt_p0 - RC_W'(1);
                end
            end
        end
    end

endmodule
